// File: rtl/tt_uart_tx.sv
// tt_uart_tx: serializes one DATA_BITS word per valid/ready handshake into an
// asynchronous frame (start, data LSB-first, optional even parity, stop).
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   data_in  in   word to transmit, captured on accept
//   valid    in   upstream has a word on data_in
//   ready    out  high only while idle; accept = valid & ready at a rising edge
//   tx       out  serial line, idles high
//   busy     out  frame in progress (inverse of ready)
//   done     out  one-cycle pulse on the last cycle of the stop bit
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit.
module tt_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  // Elaboration-time range check on the divider.
  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
    $error("tt_uart_tx: CLKS_PER_BIT must be in 2..65535");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_tx;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  logic [DATA_BITS-1:0] w_shift_next;
  assign w_shift_next = r_shift >> 1;

  // Frame sequencer; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (valid && r_ready) begin
            r_shift  <= data_in;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^data_in;
`endif
            r_state  <= S_START;
            r_cnt    <= CNT_LOAD;
            r_tx     <= 1'b0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
          end
        end

        S_START: begin
          if (r_cnt == '0) begin
            r_state <= S_DATA;
            r_cnt   <= CNT_LOAD;
            r_idx   <= '0;
            r_tx    <= r_shift[0];
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        // tx is pre-loaded with the next bit so it changes on the bit boundary.
        S_DATA: begin
          if (r_cnt == '0) begin
            r_cnt   <= CNT_LOAD;
            r_shift <= w_shift_next;
            if (r_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= r_parity;
`else
              r_state <= S_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_idx <= r_idx + IDX_W'(1);
              r_tx  <= w_shift_next[0];
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (r_cnt == '0) begin
            r_state <= S_STOP;
            r_cnt   <= CNT_LOAD;
            r_tx    <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
`endif

        // done is raised one edge early so it is high during the final stop cycle.
        S_STOP: begin
          r_tx <= 1'b1;
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt  <= r_cnt - CNT_W'(1);
            r_done <= (r_cnt == CNT_LAST);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign tx    = r_tx;
  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
